// File: rtl/stage_seq_ctrl.sv
// Sequencer that loads a six-stage one-hot clock generator, checks each advance, and counts full passes.
// Latency: start follows an accepted go by one edge; done/err follow the deciding cycle by one edge.
// No backpressure: go is ignored while busy, in DONE, and during reset; faults park the FSM in ERR.
module stage_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] n_passes,
  input  logic [5:0] stage_in,
  output logic       start,
  output logic       shift,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pass_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_LOAD = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam logic [5:0] STAGE_FIRST = 6'b000001;
  localparam logic [5:0] STAGE_LAST  = 6'b100000;
  localparam logic [3:0] LOAD_LIMIT  = 4'd15;

  state_t     state, state_n;
  logic [5:0] exp_stage, exp_stage_n;
  logic [3:0] tmo, tmo_n;
  logic [3:0] n_lat, n_lat_n;
  logic       start_n, shift_n, busy_n, done_n, err_n;
  logic [3:0] pass_cnt_n;
  logic [3:0] pass_inc;

  assign pass_inc = pass_cnt + 4'd1;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n     = state;
    exp_stage_n = exp_stage;
    tmo_n       = tmo;
    n_lat_n     = n_lat;
    start_n     = 1'b0;
    shift_n     = shift;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = err;
    pass_cnt_n  = pass_cnt;

    case (state)
      IDLE, ERR: begin
        if (go) begin
          state_n    = ARM;
          n_lat_n    = (n_passes == 4'd0) ? 4'd1 : n_passes;
          pass_cnt_n = 4'd0;
          err_n      = 1'b0;
          busy_n     = 1'b1;
          start_n    = 1'b1;
          shift_n    = 1'b0;
        end
      end
      ARM: begin
        // Generator sees start during this cycle and presents stage 0 next cycle.
        tmo_n   = 4'd0;
        state_n = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (stage_in == STAGE_FIRST) begin
          shift_n     = 1'b1;
          exp_stage_n = STAGE_FIRST;
          state_n     = RUN;
        end else if (stage_in != 6'b000000 || tmo == LOAD_LIMIT) begin
          state_n = ERR;
          err_n   = 1'b1;
          shift_n = 1'b0;
          busy_n  = 1'b0;
        end else begin
          tmo_n = tmo + 4'd1;
        end
      end
      RUN: begin
        if (stage_in != exp_stage) begin
          state_n = ERR;
          err_n   = 1'b1;
          shift_n = 1'b0;
          busy_n  = 1'b0;
        end else begin
          exp_stage_n = {exp_stage[4:0], exp_stage[5]};
          if (exp_stage == STAGE_LAST) begin
            pass_cnt_n = pass_inc;
            if (pass_inc == n_lat) begin
              shift_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end
          end
        end
      end
      DONE: begin
        // go arriving here is dropped; a fresh go is needed from IDLE.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      exp_stage <= STAGE_FIRST;
      tmo       <= 4'd0;
      n_lat     <= 4'd1;
      start     <= 1'b0;
      shift     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pass_cnt  <= 4'd0;
    end else begin
      state     <= state_n;
      exp_stage <= exp_stage_n;
      tmo       <= tmo_n;
      n_lat     <= n_lat_n;
      start     <= start_n;
      shift     <= shift_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      pass_cnt  <= pass_cnt_n;
    end
  end

endmodule
